pixel_layer_scheduler: RTL
==========================

PIXEL_LAYER_SCHEDULER -- requirements
Module: pixel_layer_scheduler

Interface
REQ-001 Parameter NUM_LAYERS, default 12: number of priority-ordered layers; index 0 is highest priority and index NUM_LAYERS-1 is the background.
REQ-002 Parameter TIMEOUT_CYCLES, default 15: SRAM acknowledge watchdog limit, used only when LAYER_TIMEOUT_EN is defined.
REQ-003 The module SHALL have one clock and a synchronous, active-low reset, named as follows:
- i_clk  in  1  rising-edge clock.
- i_rst_n  in  1  synchronous active-low reset.
REQ-004 The pixel-request interface SHALL be:
- i_pix_valid  in  1  pixel request.
- o_pix_ready  out  1  scheduler can accept a request.
- i_layer_hit  in  NUM_LAYERS  per-layer bounding-box hit for the requested pixel; sampled on accept.
REQ-005 The SRAM read interface SHALL be:
- o_sram_req  out  1  read request.
- o_sram_layer  out  clog2(NUM_LAYERS)  layer index being fetched.
- i_sram_ack  in  1  read data valid.
- i_sram_data  in  sram_pkg::COLOR_WIDTH  encoded colour.
REQ-006 The output interface toward the colour decoder SHALL be:
- o_out_valid  out  1  result valid.
- i_out_ready  in  1  downstream accepts the result.
- o_object_id  out  game_pkg::ObjectID  winning object.
- o_encoded_color  out  sram_pkg::COLOR_WIDTH  winning encoded colour.
- o_timeout_err  out  1  sticky watchdog flag.

Function
REQ-007 The FSM SHALL have exactly the states IDLE, SCAN, FETCH and OUT.
REQ-008 o_pix_ready SHALL be 1 only in IDLE.
REQ-009 A request SHALL be accepted when i_pix_valid and o_pix_ready are both 1; on accept the module SHALL latch hit_q = i_layer_hit with bit NUM_LAYERS-1 forced to 1, then go to SCAN.
REQ-010 In SCAN, the module SHALL select the lowest set index of hit_q, clear that bit, register the index, and go to FETCH on the next edge (one cycle per SCAN).
REQ-011 In FETCH, o_sram_req SHALL be 1 and o_sram_layer SHALL equal the registered index, both stable until i_sram_ack; at most one request SHALL be outstanding.
REQ-012 When i_sram_ack is 1 in FETCH, the module SHALL act as follows:
- If i_sram_data is not sram_pkg::TRANSPARENT_CODE (0), or the index is the background index, it SHALL latch the object and colour and go to OUT.
- Otherwise it SHALL return to SCAN.
REQ-013 o_object_id SHALL be game_pkg::LAYER_OBJECT[index]; the background colour SHALL be accepted as-is, even if 0.
REQ-014 i_sram_ack outside FETCH SHALL be ignored.
REQ-015 In OUT, o_out_valid SHALL be 1 with outputs held stable; when i_out_ready is 1 the module SHALL go to IDLE.
REQ-016 Best-case latency SHALL be accept -> o_sram_req in 2 cycles (SCAN then FETCH), and ack -> o_out_valid in 1 cycle.
REQ-017 Each transparent layer SHALL add 2 cycles plus SRAM latency.
REQ-018 If i_layer_hit is all zeros, only the background SHALL be fetched.
REQ-019 Simultaneous i_out_ready and i_pix_valid SHALL NOT accept the new pixel in the same cycle; it is accepted in IDLE on the following cycle.

Reset
REQ-020 When i_rst_n is 0 at a rising edge, the FSM SHALL go to IDLE, and hit_q, the index, o_sram_req, o_out_valid, o_object_id (OBJECT_MAP), o_encoded_color, o_timeout_err and the watchdog counter SHALL all reset to 0.
REQ-021 Reset asserted mid-FETCH SHALL drop o_sram_req on the next edge and abandon the pixel; a late ack SHALL be ignored per REQ-014.

Configuration
REQ-022 With LAYER_TIMEOUT_EN defined, a counter SHALL count cycles in FETCH without ack and clear on each entry to FETCH.
REQ-023 On reaching TIMEOUT_CYCLES, the module SHALL treat the layer as transparent (go to SCAN), or as colour 0 if it is the background (go to OUT), and set o_timeout_err until reset.
REQ-024 Without LAYER_TIMEOUT_EN, no counter SHALL exist, o_timeout_err SHALL be tied 0, and FETCH SHALL wait indefinitely.

Structure
REQ-025 game_pkg SHALL hold the LAYER_OBJECT[NUM_LAYERS] priority table of ObjectID (CAR1_CIRCLE, CAR2_CIRCLE, CAR1, CAR2, QBLOCK, BAR_DIGIT, BAR, START/WIN/LOSE captions, IDLE_BG, MAP last) and the scheduler state enum.
REQ-026 sram_pkg SHALL hold COLOR_WIDTH and TRANSPARENT_CODE.
REQ-027 The lowest-set-bit selector SHALL be the sub-module layer_priority_encoder (combinational, outputs index and any-valid).

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Hit 12'h001, ack 1 cycle later with data 4'h5 -> o_sram_layer 0; o_out_valid with LAYER_OBJECT[0] and colour 5; o_pix_ready 0 throughout.
- Hit 12'h006, layer 1 returns 0 and layer 2 returns 4'h3 -> two requests (1 then 2); output LAYER_OBJECT[2] with colour 3.
- Hit 12'h000, background returns 0 -> single request to layer 11; output OBJECT_MAP with colour 0.
- i_out_ready held 0 for 5 cycles -> outputs stable and o_pix_ready 0; ready=1 -> IDLE next cycle; a pending pixel is accepted one cycle later.
- Reset pulsed during FETCH, then a late ack -> o_sram_req 0 after the edge; no o_out_valid.
- LAYER_TIMEOUT_EN defined, TIMEOUT_CYCLES=15, hit 12'h001, no ack on layer 0 -> after 15 cycles the next request goes to layer 11; o_timeout_err 1.

Source files
------------

// File: rtl/game_pkg.sv
// Game-level object identifiers, the layer priority table and the scheduler state encoding.
package game_pkg;

    typedef enum logic [3:0] {
        OBJECT_MAP    = 4'd0,
        CAR1_CIRCLE   = 4'd1,
        CAR2_CIRCLE   = 4'd2,
        CAR1          = 4'd3,
        CAR2          = 4'd4,
        QBLOCK        = 4'd5,
        BAR_DIGIT     = 4'd6,
        BAR           = 4'd7,
        START_CAPTION = 4'd8,
        WIN_CAPTION   = 4'd9,
        LOSE_CAPTION  = 4'd10,
        IDLE_BG       = 4'd11
    } ObjectID;

    localparam int unsigned NUM_OBJ_LAYERS = 12;
    localparam int unsigned LAYER_IDX_W    = 4;

    // Index 0 is drawn on top; the map is the background and always last.
    localparam ObjectID LAYER_OBJECT [NUM_OBJ_LAYERS] = '{
        CAR1_CIRCLE, CAR2_CIRCLE, CAR1, CAR2, QBLOCK, BAR_DIGIT,
        BAR, START_CAPTION, WIN_CAPTION, LOSE_CAPTION, IDLE_BG, OBJECT_MAP
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FETCH = 2'd2,
        OUT   = 2'd3
    } sched_state_t;

    function automatic ObjectID layer_object(input logic [LAYER_IDX_W-1:0] idx);
        if (idx < LAYER_IDX_W'(NUM_OBJ_LAYERS))
            return LAYER_OBJECT[idx];
        return OBJECT_MAP;
    endfunction

endpackage

// File: rtl/sram_pkg.sv
// Encoded-colour format shared with the sprite SRAM.
package sram_pkg;

    localparam int unsigned COLOR_WIDTH = 4;
    localparam logic [COLOR_WIDTH-1:0] TRANSPARENT_CODE = '0;

endpackage

// File: rtl/layer_priority_encoder.sv
// Combinational lowest-set-bit selector over the pending layer mask.
module layer_priority_encoder #(
    parameter int unsigned N = 12
) (
    input  logic [N-1:0]         hits,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (hits[i] && !any) begin
                idx = ($clog2(N))'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_layer_scheduler.sv
// Walks hit layers in priority order, fetching colours until an opaque one (or the background) wins.
// Optional SRAM acknowledge watchdog is enabled by defining LAYER_TIMEOUT_EN.
module pixel_layer_scheduler
    import game_pkg::*;
    import sram_pkg::*;
#(
    parameter int unsigned NUM_LAYERS     = 12,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_pix_valid,
    output logic                          o_pix_ready,
    input  logic [NUM_LAYERS-1:0]         i_layer_hit,
    output logic                          o_sram_req,
    output logic [$clog2(NUM_LAYERS)-1:0] o_sram_layer,
    input  logic                          i_sram_ack,
    input  logic [COLOR_WIDTH-1:0]        i_sram_data,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output ObjectID                       o_object_id,
    output logic [COLOR_WIDTH-1:0]        o_encoded_color,
    output logic                          o_timeout_err
);

    localparam int unsigned IW = $clog2(NUM_LAYERS);
    localparam logic [IW-1:0] BG_IDX = IW'(NUM_LAYERS - 1);

    sched_state_t            state_q, state_d;
    logic [NUM_LAYERS-1:0]   hit_q;
    logic [IW-1:0]           idx_q;
    ObjectID                 obj_q;
    logic [COLOR_WIDTH-1:0]  color_q;
    logic [IW-1:0]           enc_idx;
    logic                    enc_any;
    logic [IW-1:0]           sel_idx;
    logic                    is_bg;
    logic                    opaque_ack;
    logic                    wd_expired;

    layer_priority_encoder #(.N(NUM_LAYERS)) u_prio (
        .hits (hit_q),
        .idx  (enc_idx),
        .any  (enc_any)
    );

    assign sel_idx    = enc_any ? enc_idx : BG_IDX;
    assign is_bg      = (idx_q == BG_IDX);
    assign opaque_ack = i_sram_ack && ((i_sram_data != TRANSPARENT_CODE) || is_bg);

`ifdef LAYER_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q;
    logic            timeout_err_q;

    // Expires on the TIMEOUT_CYCLES-th consecutive FETCH cycle without an ack.
    assign wd_expired = (state_q == FETCH) && !i_sram_ack &&
                        (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else if (state_q == SCAN) begin
            wd_cnt_q <= '0;
        end else if (state_q == FETCH && !i_sram_ack) begin
            if (wd_expired)
                timeout_err_q <= 1'b1;
            else
                wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    assign o_timeout_err = timeout_err_q;
`else
    assign wd_expired    = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (i_pix_valid) state_d = SCAN;
            SCAN:  state_d = FETCH;
            FETCH: begin
                if (i_sram_ack)
                    state_d = opaque_ack ? OUT : SCAN;
                else if (wd_expired)
                    state_d = is_bg ? OUT : SCAN;
            end
            OUT:   if (i_out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_pix_ready = (state_q == IDLE);
        o_sram_req  = (state_q == FETCH);
        o_out_valid = (state_q == OUT);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hit_q   <= '0;
            idx_q   <= '0;
            obj_q   <= OBJECT_MAP;
            color_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_pix_valid) begin
                        hit_q             <= i_layer_hit;
                        hit_q[BG_IDX]     <= 1'b1;
                    end
                end
                SCAN: begin
                    idx_q          <= sel_idx;
                    hit_q[sel_idx] <= 1'b0;
                end
                FETCH: begin
                    if (opaque_ack) begin
                        obj_q   <= layer_object(LAYER_IDX_W'(idx_q));
                        color_q <= i_sram_data;
                    end else if (!i_sram_ack && wd_expired && is_bg) begin
                        obj_q   <= layer_object(LAYER_IDX_W'(idx_q));
                        color_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sram_layer    = idx_q;
    assign o_object_id     = obj_q;
    assign o_encoded_color = color_q;

endmodule
